interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//  Sequences external-interrupt entry for the pipelined core. Captures the interrupt pin, waits for a
//  safe point in decode, and pulses i_interrupt into control_unit for one cycle (push PC + flags).
//  It then fetches the handler address from the vector slot in data memory and redirects the PC.
//  Masks further entry until the handler's RTI retires.
// PARAMETERS
//  PC_WIDTH     32     width of PC and vector word
//  ADDR_WIDTH   12     data-memory address width
//  VECTOR_ADDR  12'h0  data-memory address holding the handler PC
//  MEM_LATENCY  1      cycles from o_vec_read to valid i_mem_data (1..7)
// PORTS
//  i_clk             in   1           core clock, rising edge
//  i_rst_n           in   1           async active-low reset
//  i_int_pin         in   1           external interrupt line, synchronous to i_clk
//  i_hazard_instr    in   1           decode holds a hazard instruction (branch/CALL/RET/LDM)
//  i_stall           in   1           pipeline stall active this cycle
//  i_flush           in   1           branch/return redirect in progress
//  i_rti_retire      in   1           RTI completed write-back this cycle
//  i_mem_data        in   PC_WIDTH    data-memory read data
//  o_interrupt       out  1           to control_unit i_interrupt; pushes PC/flags
//  o_freeze_fetch    out  1           hold PC and the fetch/decode register
//  o_vec_read        out  1           data-memory read strobe for the vector
//  o_vec_addr        out  ADDR_WIDTH  equals VECTOR_ADDR while o_vec_read is high, else 0
//  o_pc_load         out  1           load o_pc_value into PC this cycle
//  o_pc_value        out  PC_WIDTH    handler address
//  o_in_service      out  1           handler active; entry masked
// BEHAVIOUR
//  Reset (async, i_rst_n=0):
//   - all outputs 0; FSM to IDLE; pending, pin-history and latency counter cleared.
//   - Applies at once in any state, including mid-sequence; no partial push or PC load may follow.
//  Capture:
//   - Rising edge of i_int_pin (0 in previous cycle, 1 now) sets pending.
//   - One level only; extra edges while pending coalesce.
//   - An edge while o_in_service is high stays pending until release.
//  FSM:
//   IDLE    -> WAIT_SAFE when pending && !o_in_service.
//   WAIT_SAFE -> INJECT in the first cycle with !i_hazard_instr && !i_stall && !i_flush.
//            o_freeze_fetch stays 0 until the safe cycle.
//   INJECT  -> o_interrupt=1 and o_freeze_fetch=1 for exactly 1 cycle; clear pending; set in_service.
//            -> VREAD.
//   VREAD   -> o_vec_read=1 for 1 cycle; load latency counter with MEM_LATENCY. -> VWAIT.
//   VWAIT   -> counter decrements each cycle; at 0, register i_mem_data into o_pc_value. -> JUMP.
//   JUMP    -> o_pc_load=1 for 1 cycle. -> IDLE.
//  o_freeze_fetch=1 from INJECT through JUMP inclusive.
//  Latency: safe cycle N -> o_interrupt at N+1 -> o_pc_load at N+3+MEM_LATENCY.
//  i_stall during VREAD/VWAIT/JUMP: the sequence continues (the memory port is owned); it is not stretched.
//  Release:
//   - i_rti_retire clears in_service, effective next cycle.
//   - i_rti_retire outside service is ignored.
//   - i_rti_retire in the same cycle as a pin edge: pending sets and in_service clears; WAIT_SAFE is
//     entered the following cycle.
//  o_pc_value holds its last handler address until the next VWAIT capture.
// STRUCTURE
//  Package cpu_pkg:
//   - isq_state_t enum {IDLE, WAIT_SAFE, INJECT, VREAD, VWAIT, JUMP} (3-bit).
//   - default VECTOR_ADDR constant.
//  Sub-module edge_detect (1-bit rising-edge detector with async active-low reset), reused for other pins.
//  Remaining logic is one FSM plus the 3-bit latency counter, in this module.
// TESTING
//  1. Reset, then a pin edge with decode idle, mem[0]=0x0000_0120, MEM_LATENCY=1:
//     -> o_interrupt 1 cycle later; o_vec_read next; o_pc_load with 0x120 four cycles after the safe cycle.
//  2. Pin edge while i_hazard_instr=1 for 3 cycles (JZ in decode):
//     -> no o_interrupt until the cycle after i_hazard_instr drops; o_freeze_fetch=0 while waiting.
//  3. Second edge during service, then i_rti_retire:
//     -> no entry before RTI; WAIT_SAFE the cycle after; full sequence repeats once.
//     Three edges during service -> exactly one extra entry.
//  4. i_rst_n low during VWAIT:
//     -> all outputs 0 immediately; no o_pc_load after release; a new edge works normally.
//  5. MEM_LATENCY=3, i_stall=1 across VWAIT:
//     -> o_pc_load exactly 6 cycles after the safe cycle, with the data sampled 3 cycles after o_vec_read.
//  6. Edge and i_rti_retire in the same cycle:
//     -> WAIT_SAFE next cycle; o_in_service 0 for exactly one cycle, then 1 at INJECT.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the core's control-side helpers.
// The interrupt sequencer imports this package for its state encoding and defaults.
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_SAFE = 3'd1,
      INJECT    = 3'd2,
      VREAD     = 3'd3,
      VWAIT     = 3'd4,
      JUMP      = 3'd5
   } isq_state_t;

   localparam logic [11:0] DEFAULT_VECTOR_ADDR = 12'h000;
   localparam int          LAT_WIDTH           = 3;

   // Decode may be interrupted only when nothing is holding or redirecting it.
   function automatic logic is_safe_point(input logic hazard, input logic stall, input logic flush);
      return !hazard && !stall && !flush;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Single-bit rising-edge detector for pins already synchronous to the core clock.
// The pulse is combinational in the cycle the pin is first seen high.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic rise
);

   logic prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_reg <= 1'b0;
      end else begin
         prev_reg <= sig;
      end
   end

   assign rise = sig & ~prev_reg;

endmodule

// File: rtl/interrupt_sequencer.sv
// External-interrupt entry sequencer: waits for a safe decode cycle, injects the interrupt,
// fetches the handler PC from the vector slot and redirects fetch; masks re-entry until RTI.
module interrupt_sequencer
   import cpu_pkg::*;
#(
   parameter int                    PC_WIDTH    = 32,
   parameter int                    ADDR_WIDTH  = 12,
   parameter logic [ADDR_WIDTH-1:0] VECTOR_ADDR = ADDR_WIDTH'(DEFAULT_VECTOR_ADDR),
   parameter int                    MEM_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_int_pin,
   input  logic                  i_hazard_instr,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic                  i_rti_retire,
   input  logic [PC_WIDTH-1:0]   i_mem_data,
   output logic                  o_interrupt,
   output logic                  o_freeze_fetch,
   output logic                  o_vec_read,
   output logic [ADDR_WIDTH-1:0] o_vec_addr,
   output logic                  o_pc_load,
   output logic [PC_WIDTH-1:0]   o_pc_value,
   output logic                  o_in_service
);

   localparam logic [LAT_WIDTH-1:0] LAT_INIT = LAT_WIDTH'(MEM_LATENCY);

   isq_state_t           state_reg, state_next;
   logic                 pending_reg, pending_next;
   logic                 in_service_reg, in_service_next;
   logic [LAT_WIDTH-1:0] lat_cnt_reg, lat_cnt_next;
   logic [PC_WIDTH-1:0]  pc_value_reg, pc_value_next;

   logic pin_rise;
   logic safe;
   logic service_blocked;
   logic capture;

   edge_detect u_pin_edge (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .sig   (i_int_pin),
      .rise  (pin_rise)
   );

   assign safe = is_safe_point(i_hazard_instr, i_stall, i_flush);

   // An RTI retiring this cycle already unmasks entry so a coincident edge goes straight to WAIT_SAFE.
   assign service_blocked = in_service_reg & ~i_rti_retire;

   assign capture = (state_reg == VWAIT) && (lat_cnt_reg <= LAT_WIDTH'(1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if ((pending_reg || pin_rise) && !service_blocked) begin
               state_next = WAIT_SAFE;
            end
         end
         WAIT_SAFE: begin
            if (safe) begin
               state_next = INJECT;
            end
         end
         INJECT:  state_next = VREAD;
         VREAD:   state_next = VWAIT;
         VWAIT: begin
            if (capture) begin
               state_next = JUMP;
            end
         end
         JUMP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      o_interrupt    = 1'b0;
      o_freeze_fetch = 1'b0;
      o_vec_read     = 1'b0;
      o_vec_addr     = '0;
      o_pc_load      = 1'b0;
      o_pc_value     = pc_value_reg;
      o_in_service   = in_service_reg;
      unique case (state_reg)
         INJECT: begin
            o_interrupt    = 1'b1;
            o_freeze_fetch = 1'b1;
         end
         VREAD: begin
            o_vec_read     = 1'b1;
            o_vec_addr     = VECTOR_ADDR;
            o_freeze_fetch = 1'b1;
         end
         VWAIT: begin
            o_freeze_fetch = 1'b1;
         end
         JUMP: begin
            o_pc_load      = 1'b1;
            o_freeze_fetch = 1'b1;
         end
         default: begin
            o_freeze_fetch = 1'b0;
         end
      endcase
   end

   always_comb begin
      // Edges coalesce into one pending level; INJECT consumes it.
      pending_next = (state_reg == INJECT) ? 1'b0 : (pending_reg | pin_rise);

      // Service is raised on the way into INJECT so the mask is visible while the push happens.
      in_service_next = in_service_reg;
      if ((state_reg == WAIT_SAFE) && safe) begin
         in_service_next = 1'b1;
      end else if (i_rti_retire) begin
         in_service_next = 1'b0;
      end

      lat_cnt_next = lat_cnt_reg;
      if (state_reg == VREAD) begin
         lat_cnt_next = LAT_INIT;
      end else if ((state_reg == VWAIT) && (lat_cnt_reg != '0)) begin
         lat_cnt_next = lat_cnt_reg - LAT_WIDTH'(1);
      end

      pc_value_next = capture ? i_mem_data : pc_value_reg;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending_reg    <= 1'b0;
         in_service_reg <= 1'b0;
         lat_cnt_reg    <= '0;
         pc_value_reg   <= '0;
      end else begin
         pending_reg    <= pending_next;
         in_service_reg <= in_service_next;
         lat_cnt_reg    <= lat_cnt_next;
         pc_value_reg   <= pc_value_next;
      end
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: two instances (latency 1 and 3) share control inputs and are
// compared every cycle against a position-in-sequence reference model, plus directed scenarios.
module tb_interrupt_sequencer;

   localparam int          L0  = 1;
   localparam int          L1  = 3;
   localparam logic [11:0] VA0 = 12'h000;
   localparam logic [11:0] VA1 = 12'h3A4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b1;
   logic int_pin = 1'b0, hazard = 1'b0, stall = 1'b0, flush = 1'b0, rti = 1'b0;
   logic [31:0] mem_data [2];

   logic        interrupt_o  [2];
   logic        freeze_o     [2];
   logic        vec_read_o   [2];
   logic        pc_load_o    [2];
   logic        in_service_o [2];
   logic [11:0] vec_addr_o   [2];
   logic [31:0] pc_value_o   [2];

   interrupt_sequencer #(.PC_WIDTH(32), .ADDR_WIDTH(12), .VECTOR_ADDR(VA0), .MEM_LATENCY(L0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_int_pin(int_pin), .i_hazard_instr(hazard),
      .i_stall(stall), .i_flush(flush), .i_rti_retire(rti), .i_mem_data(mem_data[0]),
      .o_interrupt(interrupt_o[0]), .o_freeze_fetch(freeze_o[0]), .o_vec_read(vec_read_o[0]),
      .o_vec_addr(vec_addr_o[0]), .o_pc_load(pc_load_o[0]), .o_pc_value(pc_value_o[0]),
      .o_in_service(in_service_o[0])
   );

   interrupt_sequencer #(.PC_WIDTH(32), .ADDR_WIDTH(12), .VECTOR_ADDR(VA1), .MEM_LATENCY(L1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_int_pin(int_pin), .i_hazard_instr(hazard),
      .i_stall(stall), .i_flush(flush), .i_rti_retire(rti), .i_mem_data(mem_data[1]),
      .o_interrupt(interrupt_o[1]), .o_freeze_fetch(freeze_o[1]), .o_vec_read(vec_read_o[1]),
      .o_vec_addr(vec_addr_o[1]), .o_pc_load(pc_load_o[1]), .o_pc_value(pc_value_o[1]),
      .o_in_service(in_service_o[1])
   );

   // Reference model: m_k is the cycle offset from the interrupt pulse (-1 = no sequence running).
   int          m_k    [2];
   bit          m_wait [2];
   bit          m_pend [2];
   bit          m_svc  [2];
   logic [31:0] m_pc   [2];
   logic [31:0] m_vec  [2];
   bit          m_prev;
   bit          use_fixed = 1'b0;
   logic [31:0] fixed_vec = 32'h0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   function automatic int lat(input int d);
      return (d == 0) ? L0 : L1;
   endfunction

   function automatic logic [11:0] vaddr(input int d);
      return (d == 0) ? VA0 : VA1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_prev = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_k[d] = -1; m_wait[d] = 1'b0; m_pend[d] = 1'b0; m_svc[d] = 1'b0; m_pc[d] = 32'h0;
      end
   endtask

   task automatic model_compare();
      for (int d = 0; d < 2; d++) begin
         int L;
         L = lat(d);
         check($sformatf("d%0d_interrupt", d), 32'(interrupt_o[d]), 32'(m_k[d] == 0));
         check($sformatf("d%0d_vec_read", d), 32'(vec_read_o[d]), 32'(m_k[d] == 1));
         check($sformatf("d%0d_vec_addr", d), 32'(vec_addr_o[d]), (m_k[d] == 1) ? 32'(vaddr(d)) : 32'h0);
         check($sformatf("d%0d_pc_load", d), 32'(pc_load_o[d]), 32'(m_k[d] == L + 2));
         check($sformatf("d%0d_freeze", d), 32'(freeze_o[d]), 32'(m_k[d] >= 0));
         check($sformatf("d%0d_in_service", d), 32'(in_service_o[d]), 32'(m_svc[d]));
         check($sformatf("d%0d_pc_value", d), pc_value_o[d], m_pc[d]);
      end
   endtask

   task automatic model_update();
      bit edge_seen;
      edge_seen = int_pin && !m_prev;
      for (int d = 0; d < 2; d++) begin
         int L;
         bit was_inject, set_svc;
         L = lat(d);
         was_inject = (m_k[d] == 0);
         set_svc = 1'b0;
         if (m_k[d] >= 0) begin
            if (m_k[d] == L + 1) m_pc[d] = mem_data[d];
            m_k[d] = (m_k[d] == L + 2) ? -1 : m_k[d] + 1;
         end else if (m_wait[d]) begin
            if (!hazard && !stall && !flush) begin
               m_wait[d] = 1'b0; m_k[d] = 0; set_svc = 1'b1;
            end
         end else if ((m_pend[d] || edge_seen) && !(m_svc[d] && !rti)) begin
            m_wait[d] = 1'b1;
         end
         m_pend[d] = was_inject ? 1'b0 : (m_pend[d] || edge_seen);
         if (set_svc) m_svc[d] = 1'b1;
         else if (rti) m_svc[d] = 1'b0;
      end
      m_prev = int_pin;
   endtask

   // Memory answers only in the exact cycle the read data is due; other cycles carry junk.
   task automatic drive_mem();
      for (int d = 0; d < 2; d++) begin
         if (m_k[d] == 0) m_vec[d] = use_fixed ? fixed_vec : $urandom;
         mem_data[d] = (m_k[d] == lat(d) + 1) ? m_vec[d] : $urandom;
      end
   endtask

   task automatic step(input bit p, input bit h, input bit s, input bit f, input bit r);
      int_pin = p; hazard = h; stall = s; flush = f; rti = r;
      drive_mem();
      @(negedge clk);
      model_compare();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      int_pin = 1'b0; hazard = 1'b0; stall = 1'b0; flush = 1'b0; rti = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst%0d_interrupt", d), 32'(interrupt_o[d]), 32'h0);
         check($sformatf("rst%0d_freeze", d), 32'(freeze_o[d]), 32'h0);
         check($sformatf("rst%0d_vec_read", d), 32'(vec_read_o[d]), 32'h0);
         check($sformatf("rst%0d_vec_addr", d), 32'(vec_addr_o[d]), 32'h0);
         check($sformatf("rst%0d_pc_load", d), 32'(pc_load_o[d]), 32'h0);
         check($sformatf("rst%0d_pc_value", d), pc_value_o[d], 32'h0);
         check($sformatf("rst%0d_in_service", d), 32'(in_service_o[d]), 32'h0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic finish_service();
      repeat (8) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      mem_data[0] = 32'h0;
      mem_data[1] = 32'h0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Basic entry with fixed vector; stall held across the vector wait.
      step(0, 0, 0, 0, 0);
      use_fixed = 1'b1; fixed_vec = 32'h0000_0120;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("t1_interrupt", 32'(interrupt_o[0]), 32'h1);
      step(1, 0, 1, 0, 0);
      check("t1_vec_read", 32'(vec_read_o[0]), 32'h1);
      step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      check("t1_pc_load", 32'(pc_load_o[0]), 32'h1);
      check("t1_pc_value", pc_value_o[0], 32'h0000_0120);
      step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      check("t5_pc_load_lat3", 32'(pc_load_o[1]), 32'h1);
      check("t5_pc_value_lat3", pc_value_o[1], 32'h0000_0120);
      use_fixed = 1'b0;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      check("t1_released", 32'(in_service_o[0]), 32'h0);

      // Hazard in decode for three cycles delays entry without freezing fetch.
      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check("t2_no_freeze", 32'(freeze_o[0]), 32'h0);
      check("t2_no_interrupt", 32'(interrupt_o[0]), 32'h0);
      step(1, 0, 0, 0, 0);
      check("t2_interrupt", 32'(interrupt_o[0]), 32'h1);
      step(0, 0, 0, 0, 0);
      finish_service();

      // Three edges during service coalesce into a single extra entry after RTI.
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      n = 0;
      step(0, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
      repeat (6) begin
         step(0, 0, 0, 0, 0);
         if (interrupt_o[0]) n++;
      end
      check("t3_no_entry_before_rti", 32'(n), 32'h0);
      step(0, 0, 0, 0, 1);
      check("t3_wait_safe_no_freeze", 32'(freeze_o[0]), 32'h0);
      n = 0;
      repeat (12) begin
         step(0, 0, 0, 0, 0);
         if (interrupt_o[0]) n++;
      end
      check("t3_one_extra_entry", 32'(n), 32'h1);

      // Edge coinciding with RTI: one cycle unmasked, then service again at INJECT.
      step(1, 0, 0, 0, 1);
      check("t6_gap", 32'(in_service_o[0]), 32'h0);
      step(1, 0, 0, 0, 0);
      check("t6_inject_service", 32'(in_service_o[0]), 32'h1);
      check("t6_inject", 32'(interrupt_o[0]), 32'h1);
      finish_service();

      // Reset in the middle of the vector wait.
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      do_reset();
      n = 0;
      repeat (8) begin
         step(0, 0, 0, 0, 0);
         if (pc_load_o[0] || pc_load_o[1]) n++;
      end
      check("t4_no_pc_load_after_reset", 32'(n), 32'h0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
      check("t4_reentry_pc_load", 32'(pc_load_o[0]), 32'h1);
      finish_service();

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         bit p, r, busy;
         p = ($urandom_range(0, 5) == 0) ? !int_pin : int_pin;
         busy = (m_svc[0] && m_k[0] < 0) || (m_svc[1] && m_k[1] < 0);
         r = busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            step(p, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0, r);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
